// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync-decoder state encoding.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_TOTAL  = 525;

  localparam int unsigned H_CNT_W     = 11;
  localparam int unsigned V_CNT_W     = 10;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned RGB_W       = 8;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned CSUM_W      = 16;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC1  = 2'd1,
    SYNC2  = 2'd2,
    LOCKED = 2'd3
  } sync_state_e;

  // One strobe's worth of sampled sync levels
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_sample_t;

endpackage

// File: rtl/vga_edge_sampler.sv
// Pixel-strobe generation from VGA_CLK and per-strobe falling/rising edge
// detection of HS, VS and BLANK_N. History resets high (idle-high syncs).
module vga_edge_sampler
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic vga_clk,
  input  logic hs,
  input  logic vs,
  input  logic blank_n,
  output logic stb_c,
  output logic hs_fall_c,
  output logic vs_fall_c,
  output logic blank_fall_c,
  output logic blank_rise_c
);

  sync_sample_t cur_c;
  sync_sample_t hist_q, hist_d;
  logic         vga_clk_q, vga_clk_d;

  always_comb begin
    cur_c         = '{hs: hs, vs: vs, blank_n: blank_n};
    vga_clk_d     = vga_clk;
    stb_c         = vga_clk & ~vga_clk_q;
    hist_d        = hist_q;
    if (stb_c) hist_d = cur_c;
    // Edges compare this strobe's sample against the previous strobe's
    hs_fall_c     = stb_c & hist_q.hs      & ~cur_c.hs;
    vs_fall_c     = stb_c & hist_q.vs      & ~cur_c.vs;
    blank_fall_c  = stb_c & hist_q.blank_n & ~cur_c.blank_n;
    blank_rise_c  = stb_c & ~hist_q.blank_n & cur_c.blank_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_clk_q <= 1'b1;
      hist_q    <= '1;
    end else begin
      vga_clk_q <= vga_clk_d;
      hist_q    <= hist_d;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel coordinates from sampled VGA syncs and verifies geometry.
// Optional active-pixel checksum enabled by `define VGA_DECODER_CHECKSUM_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   VGA_CLK,
  input  logic                   VGA_HS,
  input  logic                   VGA_VS,
  input  logic                   VGA_BLANK_N,
  input  logic [RGB_W-1:0]       VGA_R,
  input  logic [RGB_W-1:0]       VGA_G,
  input  logic [RGB_W-1:0]       VGA_B,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic                   ativo,
  output logic                   pix_valid,
  output logic                   locked,
  output logic                   err_linha,
  output logic                   err_quadro,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [H_CNT_W-1:0]     line_len,
  output logic [CSUM_W-1:0]      checksum
);

  logic stb, hs_fall, vs_fall, blank_fall, blank_rise;

  vga_edge_sampler u_sampler (
    .clk          (CLOCK_50),
    .rst_n        (reset),
    .vga_clk      (VGA_CLK),
    .hs           (VGA_HS),
    .vs           (VGA_VS),
    .blank_n      (VGA_BLANK_N),
    .stb_c        (stb),
    .hs_fall_c    (hs_fall),
    .vs_fall_c    (vs_fall),
    .blank_fall_c (blank_fall),
    .blank_rise_c (blank_rise)
  );

  sync_state_e            state_q, state_d;
  logic [H_CNT_W-1:0]     h_cnt_q, h_cnt_d, h_inc;
  logic [V_CNT_W-1:0]     v_cnt_q, v_cnt_d, v_inc, v_upd;
  logic [COORD_W-1:0]     x_q, x_d, x_inc, y_q, y_d, y_inc, lines_upd;
  logic [H_CNT_W:0]       h_len;
  logic                   ativo_q, ativo_d, pix_valid_q, pix_valid_d;
  logic                   locked_q, locked_d;
  logic                   err_linha_q, err_linha_d, err_quadro_q, err_quadro_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic [H_CNT_W-1:0]     line_len_q, line_len_d;
  logic                   line_bad, frame_bad, checking;

  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    ativo_d       = ativo_q;
    pix_valid_d   = stb;
    err_linha_d   = err_linha_q;
    err_quadro_d  = err_quadro_q;
    frame_count_d = frame_count_q;
    line_len_d    = line_len_q;

    // Saturating increments keep counters sane under wildly wrong timing
    h_inc = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + H_CNT_W'(1);
    v_inc = (v_cnt_q == '1) ? v_cnt_q : v_cnt_q + V_CNT_W'(1);
    x_inc = (x_q == '1) ? x_q : x_q + COORD_W'(1);
    y_inc = (y_q == '1) ? y_q : y_q + COORD_W'(1);
    h_len = (H_CNT_W + 1)'(h_cnt_q) + (H_CNT_W + 1)'(1);

    // Same-strobe HS/VS fall: the line is counted before the frame check
    v_upd     = hs_fall ? v_inc : v_cnt_q;
    lines_upd = blank_fall ? y_inc : y_q;

    line_bad  = (hs_fall & (h_len != (H_CNT_W + 1)'(H_TOTAL)))
              | (blank_fall & (x_q != COORD_W'(H_ACTIVE - 1)));
    frame_bad = vs_fall & ((v_upd != V_CNT_W'(V_TOTAL)) |
                           (lines_upd != COORD_W'(V_ACTIVE)));
    checking  = (state_q != SEARCH);

    if (stb) begin
      h_cnt_d = hs_fall ? '0 : h_inc;
      if (hs_fall) begin
        line_len_d = h_len[H_CNT_W] ? '1 : h_len[H_CNT_W-1:0];
        v_cnt_d    = v_inc;
      end
      if (vs_fall) v_cnt_d = '0;
      ativo_d = VGA_BLANK_N;
      if (blank_rise)       x_d = '0;
      else if (VGA_BLANK_N) x_d = x_inc;
      if (blank_fall) y_d = y_inc;
      if (vs_fall)    y_d = '0;
    end

    case (state_q)
      SEARCH: if (vs_fall) state_d = SYNC1;
      SYNC1: begin
        if (line_bad | frame_bad) state_d = SEARCH;
        else if (vs_fall)         state_d = SYNC2;
      end
      SYNC2: begin
        if (line_bad | frame_bad) state_d = SEARCH;
        else if (vs_fall)         state_d = LOCKED;
      end
      LOCKED: begin
        if (line_bad | frame_bad) state_d = SEARCH;
        else if (vs_fall)         frame_count_d = frame_count_q + FRAME_CNT_W'(1);
      end
      default: state_d = SEARCH;
    endcase

    if (checking & line_bad)  err_linha_d  = 1'b1;
    if (checking & frame_bad) err_quadro_d = 1'b1;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q       <= SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      ativo_q       <= 1'b0;
      pix_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      err_linha_q   <= 1'b0;
      err_quadro_q  <= 1'b0;
      frame_count_q <= '0;
      line_len_q    <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      ativo_q       <= ativo_d;
      pix_valid_q   <= pix_valid_d;
      locked_q      <= locked_d;
      err_linha_q   <= err_linha_d;
      err_quadro_q  <= err_quadro_d;
      frame_count_q <= frame_count_d;
      line_len_q    <= line_len_d;
    end
  end

`ifdef VGA_DECODER_CHECKSUM_EN
  logic [CSUM_W-1:0] acc_q, acc_d, checksum_q, checksum_d;

  // Frame checksum: running R+G+B over active strobes, latched on VS fall
  always_comb begin
    acc_d      = acc_q;
    checksum_d = checksum_q;
    if (stb & VGA_BLANK_N)
      acc_d = acc_q + CSUM_W'(VGA_R) + CSUM_W'(VGA_G) + CSUM_W'(VGA_B);
    if (vs_fall) begin
      checksum_d = acc_q;
      acc_d      = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else begin
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{VGA_R, VGA_G, VGA_B};
  assign checksum   = '0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign ativo       = ativo_q;
  assign pix_valid   = pix_valid_q;
  assign locked      = locked_q;
  assign err_linha   = err_linha_q;
  assign err_quadro  = err_quadro_q;
  assign frame_count = frame_count_q;
  assign line_len    = line_len_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 20x8 line/frame geometry
// (12x4 active) so several complete frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int TH = 20, TA = 12, TV = 8, TVA = 4;
  localparam int HS_END = 2, HA0 = 4, VA0 = 2;
`ifdef VGA_DECODER_CHECKSUM_EN
  localparam logic [15:0] CSUM_EXP = 16'd144;
`else
  localparam logic [15:0] CSUM_EXP = 16'd0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [9:0]  x, y;
  logic        ativo, pix_valid, locked, err_linha, err_quadro;
  logic [15:0] frame_count, checksum;
  logic [10:0] line_len;
  logic [67:0] outs;

  int total = 0;
  int bad   = 0;

  vga_sync_decoder #(.H_ACTIVE(TA), .H_TOTAL(TH), .V_ACTIVE(TVA), .V_TOTAL(TV)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .x(x), .y(y), .ativo(ativo), .pix_valid(pix_valid),
    .locked(locked), .err_linha(err_linha), .err_quadro(err_quadro),
    .frame_count(frame_count), .line_len(line_len), .checksum(checksum)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign outs = {x, y, ativo, pix_valid, locked, err_linha, err_quadro,
                 frame_count, line_len, checksum};

  // One pixel strobe at position (v,h); returns with outputs updated
  task automatic strobe(input int v, input int h);
    @(negedge CLOCK_50);
    VGA_CLK     = 1'b1;
    VGA_HS      = (h >= HS_END);
    VGA_VS      = (v != 0);
    VGA_BLANK_N = (h >= HA0 && h < HA0 + TA && v >= VA0 && v < VA0 + TVA);
    @(negedge CLOCK_50);
    VGA_CLK = 1'b0;
  endtask

  task automatic part(input int v, input int h0, input int h1);
    for (int h = h0; h < h1; h++) strobe(v, h);
  endtask

  task automatic lines(input int v0, input int v1);
    for (int v = v0; v < v1; v++) part(v, 0, TH);
  endtask

  task automatic test_reset;
    reset = 1'b0; VGA_CLK = 1'b1; VGA_HS = 1'b0; VGA_VS = 1'b0; VGA_BLANK_N = 1'b1;
    VGA_R = 8'd1; VGA_G = 8'd1; VGA_B = 8'd1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    total++; if (outs !== 68'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs); end
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0; reset = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    total++; if (outs !== 68'd0) begin bad++; $display("FAIL idle_outs got=%h want=0", outs); end
  endtask

  task automatic test_lock;
    lines(0, TV);
    lines(0, TV);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_after2 got=%b want=0", locked); end
    strobe(0, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_after3 got=%b want=1", locked); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL fc_at3 got=%0d want=0", frame_count); end
    total++; if (line_len !== 11'd20) begin bad++; $display("FAIL line_len got=%0d want=20", line_len); end
  endtask

  task automatic test_pixels;
    part(0, 1, TH); lines(1, 2); part(2, 0, HA0 + 1);
    total++; if ({x, y, ativo, pix_valid} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL first_px got x=%0d y=%0d a=%b v=%b want 0 0 1 1", x, y, ativo, pix_valid); end
    @(negedge CLOCK_50);
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL pix_valid_pulse got=%b want=0", pix_valid); end
    part(2, HA0 + 1, TH); lines(3, 5); part(5, 0, HA0 + TA);
    total++; if ({x, y, ativo} !== {10'd11, 10'd3, 1'b1}) begin
      bad++; $display("FAIL last_px got x=%0d y=%0d a=%b want 11 3 1", x, y, ativo); end
    strobe(5, HA0 + TA);
    total++; if ({ativo, y} !== {1'b0, 10'd4}) begin
      bad++; $display("FAIL blank_after got a=%b y=%0d want 0 4", ativo, y); end
    part(5, HA0 + TA + 1, TH); lines(6, TV); strobe(0, 0);
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL fc_at4 got=%0d want=1", frame_count); end
    total++; if (checksum !== CSUM_EXP) begin bad++; $display("FAIL checksum got=%0d want=%0d", checksum, CSUM_EXP); end
    total++; if ({locked, y} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL vs_y_reset got l=%b y=%0d want 1 0", locked, y); end
  endtask

  task automatic test_stuck_clk;
    @(negedge CLOCK_50);
    VGA_HS = 1'b0; VGA_VS = 1'b0; VGA_BLANK_N = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    total++; if ({x, y, locked, pix_valid, frame_count} !== {10'd11, 10'd0, 1'b1, 1'b0, 16'd1}) begin
      bad++; $display("FAIL stuck_hold got x=%0d y=%0d l=%b v=%b fc=%0d want 11 0 1 0 1",
                      x, y, locked, pix_valid, frame_count); end
    part(0, 1, TH);
  endtask

  task automatic test_bad_line;
    part(1, 0, TH - 1);
    strobe(2, 0);
    total++; if ({line_len, err_linha, locked, err_quadro} !== {11'd19, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL short_line got len=%0d el=%b l=%b eq=%b want 19 1 0 0",
                      line_len, err_linha, locked, err_quadro); end
    part(2, 1, TH); lines(3, TV); strobe(0, 0);
    part(0, 1, TH); lines(1, TV); lines(0, TV);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got=%b want=0", locked); end
    strobe(0, 0);
    total++; if ({locked, err_linha, frame_count} !== {1'b1, 1'b1, 16'd1}) begin
      bad++; $display("FAIL relock got l=%b el=%b fc=%0d want 1 1 1", locked, err_linha, frame_count); end
  endtask

  task automatic test_bad_frame;
    part(0, 1, TH); lines(1, TV - 1);
    total++; if (err_quadro !== 1'b0) begin bad++; $display("FAIL eq_before got=%b want=0", err_quadro); end
    strobe(0, 0);
    total++; if ({err_quadro, locked, err_linha, frame_count} !== {1'b1, 1'b0, 1'b1, 16'd1}) begin
      bad++; $display("FAIL short_frame got eq=%b l=%b el=%b fc=%0d want 1 0 1 1",
                      err_quadro, locked, err_linha, frame_count); end
  endtask

  task automatic test_reset_mid;
    part(0, 1, TH); lines(1, TV); lines(0, TV); lines(0, TV); strobe(0, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_pre_reset got=%b want=1", locked); end
    part(0, 1, TH); part(1, 0, 7);
    @(negedge CLOCK_50); reset = 1'b0;
    @(negedge CLOCK_50); reset = 1'b1;
    total++; if (outs !== 68'd0) begin bad++; $display("FAIL mid_reset got=%h want=0", outs); end
    part(1, 7, TH); lines(2, TV); lines(0, TV); lines(0, TV);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL restart_early got=%b want=0", locked); end
    strobe(0, 0);
    total++; if ({locked, err_linha, err_quadro, frame_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      bad++; $display("FAIL restart_lock got l=%b el=%b eq=%b fc=%0d want 1 0 0 0",
                      locked, err_linha, err_quadro, frame_count); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_stuck_clk();
    test_bad_line();
    test_bad_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the `vga` timing generator. It samples `VGA_CLK`, `VGA_HS`, `VGA_VS` and `VGA_BLANK_N` in the `CLOCK_50` domain and rebuilds the pixel coordinates and active flag. It checks line and frame geometry against the 640x480@60 timing and reports lock, errors and frame counts. It sits beside `tela` and serves as an on-chip monitor and a self-checking bench component.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_TOTAL`, 800: pixel strobes per line
- `V_ACTIVE`, 480: active lines per frame
- `V_TOTAL`, 525: lines per frame
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `VGA_CLK`  in  1  pixel clock, treated as data and edge-detected; synchronous to `CLOCK_50`
- `VGA_HS`, `VGA_VS`  in  1 each  syncs, active low
- `VGA_BLANK_N`  in  1  high during active video
- `VGA_R`, `VGA_G`, `VGA_B`  in  8 each  pixel colour; used only with checksum
- `x`, `y`  out  10 each  recovered active coordinates
- `ativo`  out  1  recovered active-video flag
- `pix_valid`  out  1  one-cycle pulse: `x`, `y` and `ativo` were updated
- `locked`  out  1  geometry verified
- `err_linha`, `err_quadro`  out  1 each  sticky line and frame geometry errors
- `frame_count`  out  16  frames completed while locked
- `line_len`  out  11  strobe count of the last completed line
- `checksum`  out  16  active-pixel sum of the last frame

## Operation
- Pixel strobe `stb = VGA_CLK & ~vga_clk_q`. HS, VS, BLANK_N and RGB are sampled only on `stb` cycles.
- A falling edge is detected on a strobe whose sample is 0 while the previous strobe's sample was 1.
- `h_cnt` (11 bits, saturates at 2047):
  - set to 0 on an HS fall, otherwise incremented each strobe
  - on an HS fall, `line_len <= h_cnt+1`; the line is bad if `h_cnt+1 != H_TOTAL`
- `v_cnt` counts HS falls since the last VS fall. On a VS fall the frame is bad if `v_cnt != V_TOTAL`.
- If HS and VS fall on the same strobe, the line is counted first and the frame check uses the updated `v_cnt`.
- `x` and `ativo` follow BLANK_N:
  - `x` resets to 0 on a BLANK_N rise and increments on strobes while BLANK_N is 1
  - on a BLANK_N fall the line is bad if `x != H_ACTIVE-1`
  - a BLANK_N fall increments `y`
- `y` resets to 0 on a VS fall. At that VS fall the frame is bad if the active-line count `!= V_ACTIVE`.
- FSM:
  - SEARCH goes to SYNC1 on a VS fall.
  - SYNC1 goes to SYNC2, and SYNC2 goes to LOCKED, on a VS fall with no bad line or frame since the previous VS fall.
  - In SYNC1, SYNC2 or LOCKED, any bad line or frame goes to SEARCH and sets the matching sticky flag.
  - `locked` is 1 only in LOCKED.
- `frame_count` increments (wrapping mod 2^16) on each good VS fall while already in LOCKED.
- Errors clear only on reset. Before the first VS fall (SEARCH), geometry checks are not flagged.

## Timing
- Registered outputs update on the `CLOCK_50` edge following the strobe cycle, so latency is 1 cycle. `pix_valid` pulses in that same cycle.
- `locked` rises 1 cycle after the third VS-fall strobe and falls 1 cycle after the erroneous strobe.
- Reset values: every output is 0; FSM in SEARCH; edge history set to 1 (idle-high syncs).
- Reset mid-frame: everything takes its reset value on the next edge, and the lock sequence restarts.
- `VGA_CLK` stuck: no strobes, so all state holds.

## Configuration
- `VGA_DECODER_CHECKSUM_EN` defined:
  - `acc` (16 bits) adds R+G+B on each active strobe, wrapping
  - on a VS fall, `checksum <= acc` and `acc <= 0`
- Undefined: `checksum` is tied to 0, RGB is ignored, and no accumulator is built.

## Structure
- Package `vga_timing_pkg` holds:
  - the 640x480 timing constants shared with `vga`
  - the FSM state enum (SEARCH, SYNC1, SYNC2, LOCKED)
- Sub-module `vga_edge_sampler` handles strobe generation and per-signal falling/rising-edge detection of HS, VS and BLANK_N.

## Test plan
- Stimulus held during 3 cycles of `reset=0` -> all outputs 0, FSM in SEARCH.
- Three nominal frames with `VGA_CLK = CLOCK_50/2` -> `locked=1` 1 cycle after the 3rd VS fall; `frame_count` goes 0 -> 1 at the 4th; `line_len=800`.
- Locked, first and last active pixels -> `x=0,y=0,ativo=1`, then `x=639,y=479`; next blank strobe -> `ativo=0`.
- One 799-strobe line injected while locked -> `line_len=799`, `err_linha=1`, `locked=0` next cycle; both stay until reset; relock after 3 clean VS falls.
- Checksum enabled, R=G=B=1 for a full frame -> `checksum=4096` (921600 mod 65536); with the macro undefined -> 0.
- Reset pulsed mid-line while locked -> all outputs 0 next edge.
- Frame of 524 lines -> `err_quadro=1`, `locked=0`.
